locked_pipe_adder: RTL and testbench

Parametrised, pipelined successor to the 32-bit AOR-locked ripple-carry adder. The block adds two WIDTH-bit operands through STAGES register stages. Key-controlled AND/OR gates on the carry chain corrupt the result unless the loaded key equals CORRECT_KEY. The key is loaded serially under an FSM, and operands move through a valid/ready handshake. It sits in the locked-netlist simulation flow as the device under test for key-sweep and Hamming-distance characterisation.

---
 rtl/locked_pipe_adder.sv | 176 +++++++++++++++++
 tb/tb_locked_pipe_adder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/locked_pipe_adder.sv
// rtl/locked_pipe_adder.sv - pipelined adder with key-locked AND/OR carry gates
//
// Purpose: adds two WIDTH-bit operands over STAGES pipeline slices. Key gates
// on the carry chain corrupt the sum unless the serially loaded key equals
// CORRECT_KEY.
// Optional feature macro: LOCK_HD_EN (adds key_hd_o, registered Hamming
// distance between key_reg and CORRECT_KEY).
//
// Ports:
//   clk_i, rst_ni              clock (rising edge), async active-low reset
//   key_load_i                 start a new key load (flushes pipeline)
//   key_shift_i, key_bit_i     serial key strobe / bit, MSB first
//   key_armed_o                key fully loaded
//   add1_i, add2_i, in_valid_i, in_ready_o     operand handshake
//   result_o, out_valid_o, out_ready_i         result handshake (MSB = carry)
//   key_hd_o                   popcount(key_reg ^ CORRECT_KEY) [LOCK_HD_EN]
module locked_pipe_adder #(
  parameter int                   WIDTH       = 32,
  parameter int                   STAGES      = 4,
  parameter int                   KEY_WIDTH   = 64,
  parameter logic [KEY_WIDTH-1:0] CORRECT_KEY = 64'hA87E0E812FE200DE
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             key_load_i,
  input  logic             key_shift_i,
  input  logic             key_bit_i,
  output logic             key_armed_o,
  input  logic [WIDTH-1:0] add1_i,
  input  logic [WIDTH-1:0] add2_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH:0]   result_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
`ifdef LOCK_HD_EN
  ,
  output logic [$clog2(KEY_WIDTH+1)-1:0] key_hd_o
`endif
);

  localparam int SW = WIDTH / STAGES;
  localparam int CW = $clog2(KEY_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(KEY_WIDTH - 1);

  typedef enum logic [1:0] {ST_UNKEYED, ST_LOADING, ST_ARMED} state_t;

  state_t               r_state, w_state_nxt;
  logic [KEY_WIDTH-1:0] r_key;
  logic [CW-1:0]        r_cnt;
  logic [KEY_WIDTH-1:0] w_err;
  logic [WIDTH-1:0]     w_kill, w_force;
  logic                 w_hold, w_accept;

  // Entry 0 holds freshly accepted operands; entry k holds the state after
  // slice k-1 has been added. Entry STAGES drives the outputs.
  logic [STAGES:0]  r_vld;
  logic [WIDTH-1:0] r_a   [0:STAGES];
  logic [WIDTH-1:0] r_b   [0:STAGES];
  logic [WIDTH-1:0] r_sum [0:STAGES];
  logic             r_c   [0:STAGES];
  logic [WIDTH-1:0] w_sum [1:STAGES];
  logic             w_c   [1:STAGES];

  // Key FSM
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_UNKEYED;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (key_load_i) begin
      w_state_nxt = ST_LOADING;
    end else if (r_state == ST_LOADING && key_shift_i && r_cnt == LAST_BIT) begin
      w_state_nxt = ST_ARMED;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_key <= '0;
      r_cnt <= '0;
    end else if (key_load_i) begin
      r_key <= '0;
      r_cnt <= '0;
    end else if (r_state == ST_LOADING && key_shift_i) begin
      r_key <= {r_key[KEY_WIDTH-2:0], key_bit_i};
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign key_armed_o = (r_state == ST_ARMED);

  // Lock gates: key bit j lands on carry j mod WIDTH; AND gate where the
  // correct bit is 1, OR gate where it is 0.
  assign w_err = r_key ^ CORRECT_KEY;

  always_comb begin
    w_kill  = '0;
    w_force = '0;
    for (int j = 0; j < KEY_WIDTH; j++) begin
      if (CORRECT_KEY[j]) w_kill[j % WIDTH]  = w_kill[j % WIDTH]  | w_err[j];
      else                w_force[j % WIDTH] = w_force[j % WIDTH] | w_err[j];
    end
  end

  // Slice adders; the gated carry feeds both the sum bit and the next carry.
  always_comb begin
    logic c;
    int   idx;
    c   = 1'b0;
    idx = 0;
    for (int k = 1; k <= STAGES; k++) begin
      w_sum[k] = r_sum[k-1];
      c        = r_c[k-1];
      for (int i = 0; i < SW; i++) begin
        idx = (k - 1) * SW + i;
        c   = (c & ~w_kill[idx]) | w_force[idx];
        w_sum[k][idx] = r_a[k-1][idx] ^ r_b[k-1][idx] ^ c;
        c   = (r_a[k-1][idx] & r_b[k-1][idx]) | ((r_a[k-1][idx] ^ r_b[k-1][idx]) & c);
      end
      w_c[k] = c;
    end
  end

  assign w_hold     = out_valid_o && !out_ready_i;
  assign in_ready_o = (r_state == ST_ARMED) && !w_hold;
  assign w_accept   = in_valid_i && in_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vld <= '0;
      for (int k = 0; k <= STAGES; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
        r_c[k]   <= 1'b0;
      end
    end else if (key_load_i) begin
      r_vld <= '0;
    end else if (!w_hold) begin
      r_vld    <= {r_vld[STAGES-1:0], w_accept};
      r_a[0]   <= add1_i;
      r_b[0]   <= add2_i;
      r_sum[0] <= '0;
      r_c[0]   <= 1'b0;
      for (int k = 1; k <= STAGES; k++) begin
        r_a[k]   <= r_a[k-1];
        r_b[k]   <= r_b[k-1];
        r_sum[k] <= w_sum[k];
        r_c[k]   <= w_c[k];
      end
    end
  end

  assign out_valid_o = r_vld[STAGES];
  assign result_o    = {r_c[STAGES], r_sum[STAGES]};

`ifdef LOCK_HD_EN
  function automatic logic [CW-1:0] popcnt(input logic [KEY_WIDTH-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int j = 0; j < KEY_WIDTH; j++) n = n + CW'(v[j]);
    return n;
  endfunction

  localparam logic [CW-1:0] HD_RST = popcnt(CORRECT_KEY);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) key_hd_o <= HD_RST;
    else         key_hd_o <= popcnt(w_err);
  end
`endif

endmodule

// File: tb/tb_locked_pipe_adder.sv
// tb/tb_locked_pipe_adder.sv - directed self-checking bench for locked_pipe_adder
module tb_locked_pipe_adder;

  localparam logic [63:0] CK = 64'hA87E0E812FE200DE;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        key_load_i, key_shift_i, key_bit_i, key_armed_o;
  logic [31:0] add1_i, add2_i;
  logic        in_valid_i, in_ready_o;
  logic [32:0] result_o;
  logic        out_valid_o, out_ready_i;
`ifdef LOCK_HD_EN
  logic [6:0]  key_hd_o;
`endif

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  locked_pipe_adder dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .key_load_i  (key_load_i),
    .key_shift_i (key_shift_i),
    .key_bit_i   (key_bit_i),
    .key_armed_o (key_armed_o),
    .add1_i      (add1_i),
    .add2_i      (add2_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .result_o    (result_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
`ifdef LOCK_HD_EN
    ,
    .key_hd_o    (key_hd_o)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Load a key with one idle gap between strobes; checks the flush on load,
  // that nothing is accepted or emitted while loading, and the arm timing.
  task automatic load_key(input logic [63:0] k);
    int rdy_seen;
    int vld_seen;
    rdy_seen = 0;
    vld_seen = 0;
    @(negedge clk);
    key_load_i = 1'b1;
    in_valid_i = 1'b0;
    @(negedge clk);
    key_load_i = 1'b0;
    check("load_flush_vld", out_valid_o, 0);
    for (int i = 63; i >= 0; i--) begin
      rdy_seen += int'(in_ready_o);
      vld_seen += int'(out_valid_o);
      if (i == 40) begin
        key_shift_i = 1'b0;
        @(negedge clk);
      end
      if (i == 0) check("armed_early", key_armed_o, 0);
      key_shift_i = 1'b1;
      key_bit_i   = k[i];
      @(negedge clk);
    end
    key_shift_i = 1'b0;
    check("load_rdy_seen", rdy_seen, 0);
    check("load_vld_seen", vld_seen, 0);
    check("armed", key_armed_o, 1);
  endtask

  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [32:0] exp);
    int lat;
    lat = 0;
    @(negedge clk);
    add1_i      = a;
    add2_i      = b;
    in_valid_i  = 1'b1;
    out_ready_i = 1'b1;
    #1;
    check({tag, "_rdy"}, in_ready_o, 1);
    @(negedge clk);
    in_valid_i = 1'b0;
    while (!out_valid_o && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, 4);
    check({tag, "_res"}, result_o, exp);
  endtask

  logic [31:0] sa [8];
  logic [31:0] sb [8];
  logic [32:0] se [8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, rcv, cnt;
    sa = '{32'h00000001, 32'h12345678, 32'hFFFFFFFF, 32'h80000000,
           32'h0000FFFF, 32'hDEADBEEF, 32'h7FFFFFFF, 32'hAAAAAAAA};
    sb = '{32'h00000002, 32'h11111111, 32'hFFFFFFFF, 32'h80000000,
           32'h00000001, 32'h00000000, 32'h00000001, 32'h55555555};
    se = '{33'h0_00000003, 33'h0_23456789, 33'h1_FFFFFFFE, 33'h1_00000000,
           33'h0_00010000, 33'h0_DEADBEEF, 33'h0_80000000, 33'h0_FFFFFFFF};

    rst_ni = 1'b0; key_load_i = 1'b0; key_shift_i = 1'b0; key_bit_i = 1'b0;
    add1_i = '0; add2_i = '0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_armed", key_armed_o, 0);
    check("rst_vld", out_valid_o, 0);
    check("rst_rdy", in_ready_o, 0);
    check("rst_res", result_o, 0);
`ifdef LOCK_HD_EN
    check("rst_hd", key_hd_o, 29);
`endif
    rst_ni = 1'b1;

    // Correct key
    load_key(CK);
    run_one("ck_ovf", 32'hFFFFFFFF, 32'h00000001, 33'h1_00000000);
`ifdef LOCK_HD_EN
    check("ck_hd", key_hd_o, 0);
`endif
    // Strobes outside LOADING must not disturb the key
    @(negedge clk);
    key_shift_i = 1'b1;
    key_bit_i   = 1'b1;
    repeat (2) @(negedge clk);
    key_shift_i = 1'b0;
    check("shift_ign_armed", key_armed_o, 1);
    run_one("shift_ign", 32'h00000003, 32'h00000004, 33'h0_00000007);

    // Bit 1 wrong: AND gate kills carry into bit 1
    load_key(64'hA87E0E812FE200DC);
    run_one("and_gate", 32'h00000001, 32'h00000001, 33'h0_00000000);
`ifdef LOCK_HD_EN
    check("and_hd", key_hd_o, 1);
`endif

    // Bit 0 wrong: OR gate forces carry into bit 0
    load_key(64'hA87E0E812FE200DF);
    run_one("or_gate", 32'h00000000, 32'h00000000, 33'h0_00000001);

    // Stream of 8 with a 3-cycle consumer stall
    load_key(CK);
    sent = 0;
    rcv  = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      in_valid_i  = (sent < 8);
      add1_i      = sa[sent % 8];
      add2_i      = sb[sent % 8];
      out_ready_i = !(cyc >= 6 && cyc <= 8);
      #1;
      if (out_valid_o) begin
        if (rcv < 8) check("stream_res", result_o, se[rcv]);
        else         check("stream_dup", rcv, 8);
        if (out_ready_i) rcv++;
      end
      if (!out_ready_i) begin
        check("stall_vld", out_valid_o, 1);
        check("stall_rdy", in_ready_o, 0);
      end
      if (in_valid_i && in_ready_o) sent++;
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    check("stream_sent", sent, 8);
    check("stream_rcv", rcv, 8);

    // Reload with three operations in flight
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      add1_i     = 32'(k + 1);
      add2_i     = 32'h10;
      in_valid_i = 1'b1;
      #1;
      check("flight_rdy", in_ready_o, 1);
    end
    load_key(CK);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      cnt += int'(out_valid_o);
    end
    check("no_stale", cnt, 0);
    run_one("after_flush", 32'h0000000F, 32'h00000001, 33'h0_00000010);

    // Asynchronous reset pulse between edges while ARMED
    @(negedge clk);
    add1_i      = 32'h5;
    add2_i      = 32'h6;
    in_valid_i  = 1'b1;
    out_ready_i = 1'b0;
    @(negedge clk);
    in_valid_i = 1'b0;
    cnt = 0;
    while (!out_valid_o && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("pre_rst_vld", out_valid_o, 1);
    check("pre_rst_res", result_o, 33'h0_0000000B);
    out_ready_i = 1'b1;
    #1;
    check("pre_rst_rdy", in_ready_o, 1);
    #1;
    rst_ni = 1'b0;
    #1;
    check("arst_armed", key_armed_o, 0);
    check("arst_vld", out_valid_o, 0);
    check("arst_rdy", in_ready_o, 0);
    check("arst_res", result_o, 0);
`ifdef LOCK_HD_EN
    check("arst_hd", key_hd_o, 29);
`endif
    rst_ni = 1'b1;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid_i = 1'b1;
      #1;
      cnt += int'(in_ready_o) + int'(out_valid_o);
    end
    in_valid_i = 1'b0;
    check("post_rst_idle", cnt, 0);
    load_key(CK);
    run_one("post_rst", 32'h80000000, 32'h7FFFFFFF, 33'h0_FFFFFFFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
